uart_byte_rx: RTL



---
 rtl/uart_byte_rx_pkg.sv | 14 +
 rtl/uart_byte_rx_sync_2ff.sv | 26 ++
 rtl/uart_byte_rx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_byte_rx_pkg.sv
// Shared UART receiver types and the default bit period used by the transmitter and bench.
package uart_byte_rx_pkg;

  localparam int UART_CLKS_PER_BIT = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

endpackage

// File: rtl/uart_byte_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 oversampling UART receiver with a single-entry valid/ready holding register,
// framing-error and overrun pulses.
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic           w_rx_s;
  uart_rx_state_t r_state;
  uart_rx_state_t w_next_state;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_next;
  logic [2:0]     r_bit_idx;
  logic [2:0]     w_bit_idx_next;
  logic [7:0]     r_shreg;
  logic [7:0]     w_shreg_next;
  logic           w_byte_done;
  logic           w_stop_bad;
  logic           w_accept;
  logic [7:0]     r_out_data;
  logic           r_out_valid;
  logic           r_frame_err;
  logic           r_overrun;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shreg   <= w_shreg_next;
    end
  end

  // Every sample point clears cnt explicitly, so the counter never relies on wrap-around.
  always_comb begin
    w_next_state   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shreg_next   = r_shreg;
    w_byte_done    = 1'b0;
    w_stop_bad     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_cnt_next   = '0;
          w_next_state = START;
        end
      end
      START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_next = '0;
          if (w_rx_s) begin
            w_next_state = IDLE;
          end else begin
            w_bit_idx_next = '0;
            w_next_state   = DATA;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_next              = '0;
          w_shreg_next[r_bit_idx] = w_rx_s;
          w_bit_idx_next          = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_next_state = STOP;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_next = '0;
          if (w_rx_s) begin
            w_byte_done  = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_stop_bad   = 1'b1;
            w_next_state = WAIT_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (w_rx_s) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_accept = r_out_valid && out_ready;

  // A completed byte may replace the held one only if the held one leaves on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_byte_done && r_out_valid && !out_ready;
      if (w_byte_done && (!r_out_valid || out_ready)) begin
        r_out_data  <= r_shreg;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
